bg_pp_sequencer: RTL and testbench

- Per-pulse sequencer for the post-processing chain.
- Waits for each laser trigger and averages a window of pre-echo ADC samples into a background value.
- Then enables the background-deduction stage over the signal window, waits for that stage's done pulse, and repeats for a programmed number of pulses.
- Sits between the ADC capture interface and the background-deduction datapath; its only other interface is the host start/abort control.

---
 rtl/pp_pkg.sv | 25 ++
 rtl/bg_pp_sequencer_if.sv | 45 ++++
 rtl/bg_avg_acc.sv | 47 ++++
 rtl/bg_pp_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bg_pp_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared constants and state encoding for the post-processing chain
package pp_pkg;

  localparam int DATA_W_DEF      = 14;
  localparam int BG_LEN_LOG2_DEF = 6;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
  localparam logic [2:0] ST_BG_ACC    = 3'd2;
  localparam logic [2:0] ST_BG_AVG    = 3'd3;
  localparam logic [2:0] ST_DEDUCT    = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_TRIG = ST_WAIT_TRIG,
    S_BG_ACC    = ST_BG_ACC,
    S_BG_AVG    = ST_BG_AVG,
    S_DEDUCT    = ST_DEDUCT,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_FINISH    = ST_FINISH
  } state_e;

endpackage

// File: rtl/bg_pp_sequencer_if.sv
// rtl/bg_pp_sequencer_if.sv - host control, ADC capture and deduction-stage signals of the sequencer
// tmo_err exists only when PP_DONE_TIMEOUT_EN is defined.
interface bg_pp_sequencer_if import pp_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GATE_CNT_W  = 16,
  parameter int PULSE_CNT_W = 16
) ();

  logic                   start;
  logic                   abort;
  logic [PULSE_CNT_W-1:0] pulse_num;
  logic [GATE_CNT_W-1:0]  sample_num;
  logic                   trig_in;
  logic                   adc_valid;
  logic [DATA_W-1:0]      adc_data;
  logic                   bg_ded_done;
  logic                   bg_ded_en;
  logic                   data_valid_out;
  logic [DATA_W-1:0]      bg_value;
  logic                   bg_value_valid;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic                   busy;
  logic                   run_done;
  logic                   trig_err;
`ifdef PP_DONE_TIMEOUT_EN
  logic                   tmo_err;
`endif

  modport master (
    output start, abort, pulse_num, sample_num, trig_in, adc_valid, adc_data, bg_ded_done,
    input  bg_ded_en, data_valid_out, bg_value, bg_value_valid, pulse_cnt, busy, run_done, trig_err
`ifdef PP_DONE_TIMEOUT_EN
    , input tmo_err
`endif
  );

  modport slave (
    input  start, abort, pulse_num, sample_num, trig_in, adc_valid, adc_data, bg_ded_done,
    output bg_ded_en, data_valid_out, bg_value, bg_value_valid, pulse_cnt, busy, run_done, trig_err
`ifdef PP_DONE_TIMEOUT_EN
    , output tmo_err
`endif
  );

endinterface

// File: rtl/bg_avg_acc.sv
// rtl/bg_avg_acc.sv - background accumulator with floor average over 2^BG_LEN_LOG2 samples
module bg_avg_acc #(
  parameter int DATA_W      = 14,
  parameter int BG_LEN_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic [DATA_W-1:0] avg
);

  localparam int ACC_W = DATA_W + BG_LEN_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BG_LEN_LOG2-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{BG_LEN_LOG2{data[DATA_W-1]}}, data};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // the counter wraps to zero on the last sample, so all-ones marks the final one
  assign done = en && !clr && (&cnt_q);
  // dropping the low bits of a two's-complement sum is an arithmetic shift, i.e. floor
  assign avg  = acc_q[ACC_W-1:BG_LEN_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bg_pp_sequencer.sv
// rtl/bg_pp_sequencer.sv - per-pulse background averaging and deduction-window sequencer
// PP_DONE_TIMEOUT_EN adds a WAIT_DONE watchdog with a tmo_err pulse.
module bg_pp_sequencer import pp_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BG_LEN_LOG2 = BG_LEN_LOG2_DEF,
  parameter int GATE_CNT_W  = 16,
  parameter int PULSE_CNT_W = 16
`ifdef PP_DONE_TIMEOUT_EN
  , parameter int DONE_TMO  = 32
`endif
) (
  input logic              clk,
  input logic              rst_n,
  bg_pp_sequencer_if.slave bus
);

  state_e                 state_q, state_d;
  logic [PULSE_CNT_W-1:0] pulse_num_q, pulse_num_d;
  logic [PULSE_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [PULSE_CNT_W-1:0] pulse_cnt_inc;
  logic [GATE_CNT_W-1:0]  sample_num_q, sample_num_d;
  logic [GATE_CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [DATA_W-1:0]      bg_value_q, bg_value_d;
  logic                   trig_err_q, trig_err_d;
  logic                   dv_q, dv_d;
  logic                   zero_done_q, zero_done_d;
  logic                   acc_clr, acc_en, acc_done;
  logic [DATA_W-1:0]      acc_avg;
  logic                   done_evt;

  assign acc_clr = (state_q == S_WAIT_TRIG) && bus.trig_in;
  assign acc_en  = (state_q == S_BG_ACC) && bus.adc_valid && !bus.abort;

  bg_avg_acc #(
    .DATA_W      (DATA_W),
    .BG_LEN_LOG2 (BG_LEN_LOG2)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .data  (bus.adc_data),
    .done  (acc_done),
    .avg   (acc_avg)
  );

`ifdef PP_DONE_TIMEOUT_EN
  localparam int TMO_W = $clog2(DONE_TMO + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  always_comb begin
    tmo_hit   = (state_q == S_WAIT_DONE) && !bus.bg_ded_done && (tmo_cnt_q == TMO_W'(DONE_TMO - 1));
    tmo_cnt_d = ((state_q == S_WAIT_DONE) && !bus.bg_ded_done) ? tmo_cnt_q + 1'b1 : '0;
    done_evt  = bus.bg_ded_done | tmo_hit;
  end

  assign bus.tmo_err = tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign done_evt = bus.bg_ded_done;
`endif

  assign pulse_cnt_inc = pulse_cnt_q + 1'b1;
  assign bg_value_d    = (state_q == S_BG_AVG) ? acc_avg : bg_value_q;

  always_comb begin
    state_d      = state_q;
    pulse_num_d  = pulse_num_q;
    sample_num_d = sample_num_q;
    pulse_cnt_d  = pulse_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    trig_err_d   = trig_err_q;
    dv_d         = 1'b0;
    zero_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.pulse_num != '0) begin
            pulse_num_d  = bus.pulse_num;
            sample_num_d = bus.sample_num;
            pulse_cnt_d  = '0;
            trig_err_d   = 1'b0;
            state_d      = S_WAIT_TRIG;
          end else begin
            zero_done_d  = 1'b1;
          end
        end
      end
      S_WAIT_TRIG: if (bus.trig_in) state_d = S_BG_ACC;
      S_BG_ACC:    if (acc_done) state_d = S_BG_AVG;
      S_BG_AVG: begin
        gate_cnt_d = '0;
        state_d    = S_DEDUCT;
      end
      S_DEDUCT: begin
        if (sample_num_q == '0) begin
          state_d = S_WAIT_DONE;
        end else if (bus.adc_valid) begin
          dv_d       = 1'b1;
          gate_cnt_d = gate_cnt_q + 1'b1;
          if (gate_cnt_q == sample_num_q - 1'b1) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_evt) begin
          pulse_cnt_d = pulse_cnt_inc;
          state_d     = (pulse_cnt_inc == pulse_num_q) ? S_FINISH : S_WAIT_TRIG;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.trig_in && (state_q inside {S_BG_ACC, S_BG_AVG, S_DEDUCT, S_WAIT_DONE}))
      trig_err_d = 1'b1;
    // abort wins over every transition and leaves the completed-pulse count intact
    if (bus.abort) begin
      state_d     = S_IDLE;
      dv_d        = 1'b0;
      zero_done_d = 1'b0;
      pulse_cnt_d = pulse_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pulse_num_q  <= '0;
      sample_num_q <= '0;
      pulse_cnt_q  <= '0;
      gate_cnt_q   <= '0;
      bg_value_q   <= '0;
      trig_err_q   <= 1'b0;
      dv_q         <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_num_q  <= pulse_num_d;
      sample_num_q <= sample_num_d;
      pulse_cnt_q  <= pulse_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      bg_value_q   <= bg_value_d;
      trig_err_q   <= trig_err_d;
      dv_q         <= dv_d;
      zero_done_q  <= zero_done_d;
    end
  end

  assign bus.bg_ded_en      = (state_q == S_DEDUCT) || (state_q == S_WAIT_DONE);
  assign bus.data_valid_out = dv_q;
  assign bus.bg_value       = bg_value_d;
  assign bus.bg_value_valid = (state_q == S_BG_AVG);
  assign bus.pulse_cnt      = pulse_cnt_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.run_done       = (state_q == S_FINISH) || zero_done_q;
  assign bus.trig_err       = trig_err_q;

endmodule

// File: tb/tb_bg_pp_sequencer.sv
// tb/tb_bg_pp_sequencer.sv - self-checking bench for bg_pp_sequencer
module tb_bg_pp_sequencer;

  typedef struct {
    int a0;
    int a1;
    int sn;
    int exp_bg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bg_pp_sequencer_if #(.DATA_W(14), .GATE_CNT_W(16), .PULSE_CNT_W(16)) ifc ();

  bg_pp_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_bgv = 0, n_dv = 0, n_rd = 0, n_busy = 0, n_tmo = 0;
  int last_bg = 0;
  int bg_buf[64];
  vec_t tbl[7];

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.bg_value_valid) begin
        n_bgv++;
        last_bg = int'($signed(ifc.bg_value));
      end
      if (ifc.data_valid_out) n_dv++;
      if (ifc.run_done) n_rd++;
      if (ifc.busy) n_busy++;
`ifdef PP_DONE_TIMEOUT_EN
      if (ifc.tmo_err) n_tmo++;
`endif
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_avg();
    int s = 0;
    for (int i = 0; i < 64; i++) s += bg_buf[i];
    return (s >= 0) ? s / 64 : -((-s + 63) / 64);
  endfunction

  task automatic do_start(input int pn, input int sn);
    ifc.pulse_num  = 16'(pn);
    ifc.sample_num = 16'(sn);
    ifc.start      = 1'b1;
    tick();
    ifc.start      = 1'b0;
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (ifc.bg_ded_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_en_wait"}, int'(ifc.bg_ded_en === 1'b1), 1);
  endtask

  task automatic send_bg(input bit gaps);
    ifc.trig_in = 1'b1;
    tick();
    ifc.trig_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      ifc.adc_valid = 1'b1;
      ifc.adc_data  = 14'(bg_buf[i]);
      tick();
      ifc.adc_valid = 1'b0;
    end
  endtask

  task automatic run_pulse(input string nm, input int sn, input bit gaps, input int exp_bg,
                           input int exp_cnt, input bit last, input bit trig_mid, input bit do_done);
    int bgv0 = n_bgv;
    int dv0  = n_dv;
    send_bg(gaps);
    wait_en(nm);
    chk({nm, "_bgv_pulses"}, n_bgv - bgv0, 1);
    chk({nm, "_bg_value"}, last_bg, exp_bg);
    for (int i = 0; i < sn; i++) begin
      if (trig_mid && i == sn / 2) begin
        ifc.trig_in = 1'b1;
        tick();
        ifc.trig_in = 1'b0;
      end
      if (gaps && $urandom_range(0, 2) == 0) tick();
      ifc.adc_valid = 1'b1;
      ifc.adc_data  = 14'($urandom);
      tick();
      ifc.adc_valid = 1'b0;
    end
    tick();
    tick();
    chk({nm, "_dv_count"}, n_dv - dv0, sn);
    chk({nm, "_en_wait_done"}, int'(ifc.bg_ded_en), 1);
    if (do_done) begin
      ifc.bg_ded_done = 1'b1;
      tick();
      ifc.bg_ded_done = 1'b0;
      chk({nm, "_pulse_cnt"}, int'(ifc.pulse_cnt), exp_cnt);
      chk({nm, "_run_done"}, int'(ifc.run_done), int'(last));
    end
  endtask

  task automatic fill_const(input int a0, input int a1);
    for (int i = 0; i < 64; i++) bg_buf[i] = (i < 32) ? a0 : a1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int rd0, bsy0, bgv0, pn, sn;
    tbl[0] = '{100, 100, 8, 100};
    tbl[1] = '{-3, -4, 5, -4};
    tbl[2] = '{1, 0, 3, 0};
    tbl[3] = '{7, 8, 0, 7};
    tbl[4] = '{5, -6, 2, -1};
    tbl[5] = '{-8192, -8192, 1, -8192};
    tbl[6] = '{8191, 8191, 4, 8191};

    ifc.start = 0; ifc.abort = 0; ifc.pulse_num = 0; ifc.sample_num = 0;
    ifc.trig_in = 0; ifc.adc_valid = 0; ifc.adc_data = 0; ifc.bg_ded_done = 0;
    repeat (3) tick();
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_en", int'(ifc.bg_ded_en), 0);
    chk("rst_dv", int'(ifc.data_valid_out), 0);
    chk("rst_bg_value", int'(ifc.bg_value), 0);
    chk("rst_bgv", int'(ifc.bg_value_valid), 0);
    chk("rst_pulse_cnt", int'(ifc.pulse_cnt), 0);
    chk("rst_run_done", int'(ifc.run_done), 0);
    chk("rst_trig_err", int'(ifc.trig_err), 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 7; t++) begin
      fill_const(tbl[t].a0, tbl[t].a1);
      rd0 = n_rd;
      do_start(1, tbl[t].sn);
      chk($sformatf("vec%0d_busy", t), int'(ifc.busy), 1);
      run_pulse($sformatf("vec%0d", t), tbl[t].sn, 0, tbl[t].exp_bg, 1, 1, 0, 1);
      tick();
      chk($sformatf("vec%0d_idle", t), int'(ifc.busy), 0);
      chk($sformatf("vec%0d_run_done_cnt", t), n_rd - rd0, 1);
    end

    for (int r = 0; r < 4; r++) begin
      pn = (r == 0) ? 3 : int'($urandom_range(1, 3));
      sn = int'($urandom_range(0, 12));
      rd0 = n_rd;
      do_start(pn, sn);
      for (int k = 0; k < pn; k++) begin
        for (int i = 0; i < 64; i++) bg_buf[i] = int'($urandom_range(0, 16383)) - 8192;
        run_pulse($sformatf("rnd%0d_p%0d", r, k), sn, 1, model_avg(), k + 1, (k == pn - 1), 0, 1);
      end
      tick();
      chk($sformatf("rnd%0d_run_done_cnt", r), n_rd - rd0, 1);
    end

    fill_const(50, 50);
    do_start(1, 8);
    run_pulse("trig_ded", 8, 0, 50, 1, 1, 1, 1);
    tick();
    chk("trig_err_sticky", int'(ifc.trig_err), 1);
    do_start(1, 1);
    chk("trig_err_clear", int'(ifc.trig_err), 0);
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;

    rd0 = n_rd;
    bgv0 = n_bgv;
    do_start(2, 3);
    ifc.trig_in = 1'b1;
    tick();
    ifc.trig_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifc.adc_valid = 1'b1;
      ifc.adc_data  = 14'd9;
      tick();
    end
    ifc.abort = 1'b1;
    ifc.adc_valid = 1'b0;
    tick();
    ifc.abort = 1'b0;
    chk("abort_acc_busy", int'(ifc.busy), 0);
    chk("abort_acc_en", int'(ifc.bg_ded_en), 0);
    chk("abort_acc_pulse_cnt", int'(ifc.pulse_cnt), 0);
    repeat (3) tick();
    chk("abort_acc_no_run_done", n_rd - rd0, 0);
    chk("abort_acc_no_bgv", n_bgv - bgv0, 0);

    rd0 = n_rd;
    fill_const(-20, 20);
    do_start(2, 2);
    run_pulse("abort_wd_p0", 2, 0, 0, 1, 0, 0, 1);
    run_pulse("abort_wd_p1", 2, 0, 0, 2, 0, 0, 0);
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    chk("abort_wd_busy", int'(ifc.busy), 0);
    chk("abort_wd_en", int'(ifc.bg_ded_en), 0);
    chk("abort_wd_dv", int'(ifc.data_valid_out), 0);
    chk("abort_wd_pulse_cnt", int'(ifc.pulse_cnt), 1);
    repeat (3) tick();
    chk("abort_wd_no_run_done", n_rd - rd0, 0);

    rd0 = n_rd;
    bsy0 = n_busy;
    do_start(0, 5);
    chk("zero_run_done", int'(ifc.run_done), 1);
    chk("zero_busy", int'(ifc.busy), 0);
    tick();
    chk("zero_run_done_end", int'(ifc.run_done), 0);
    chk("zero_busy_never", n_busy - bsy0, 0);
    chk("zero_run_done_cnt", n_rd - rd0, 1);

    do_start(1, 4);
    ifc.trig_in = 1'b1;
    tick();
    ifc.trig_in = 1'b0;
    ifc.adc_valid = 1'b1;
    repeat (5) tick();
    ifc.adc_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(ifc.busy), 0);
    chk("async_rst_pulse_cnt", int'(ifc.pulse_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PP_DONE_TIMEOUT_EN
    begin
      int n = 0;
      int t0 = n_tmo;
      fill_const(0, 0);
      do_start(1, 0);
      send_bg(0);
      wait_en("tmo");
      while (ifc.tmo_err !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("tmo_latency", n, 32);
      tick();
      chk("tmo_pulse_cnt", int'(ifc.pulse_cnt), 1);
      chk("tmo_run_done", int'(ifc.run_done), 1);
      chk("tmo_pulses", n_tmo - t0, 1);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
